// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: command-byte sequencer for the UART loader path.
// Streams a writable byte table (optionally gapped and repeated) into a valid/ready byte
// sink, then counts and XOR-checksums response bytes and flags completion or timeout.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   tbl_wr_en_i/addr_i/data_i      table write port (ignored while busy_o)
//   seq_len_i, gap_i, loop_cnt_i   bytes per pass, idle cycles per byte, extra passes
//   rsp_len_i                      expected response byte count
//   start_i, abort_i               start pulse (ignored while busy_o), abort (top priority)
//   tx_data_o, tx_data_vld_o, tx_data_rdy_i   byte stream to sink
//   rx_data_i, rx_data_vld_i, rx_data_rdy_o   response stream (never back-pressured)
//   busy_o, done_o, timeout_o      status: in progress, completion pulse, sticky timeout
//   tx_cnt_o, rsp_cnt_o, rsp_sum_o bytes sent, responses counted, response XOR
module uart_cmd_seq #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned GW    = 16,
  parameter int unsigned TMO   = 100000,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          tbl_wr_en_i,
  input  logic [AW-1:0] tbl_wr_addr_i,
  input  logic [DW-1:0] tbl_wr_data_i,
  input  logic [AW:0]   seq_len_i,
  input  logic [GW-1:0] gap_i,
  input  logic [7:0]    loop_cnt_i,
  input  logic [15:0]   rsp_len_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [DW-1:0] tx_data_o,
  output logic          tx_data_vld_o,
  input  logic          tx_data_rdy_i,
  input  logic [DW-1:0] rx_data_i,
  input  logic          rx_data_vld_i,
  output logic          rx_data_rdy_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_o,
  output logic [15:0]   tx_cnt_o,
  output logic [15:0]   rsp_cnt_o,
  output logic [DW-1:0] rsp_sum_o
);

  localparam int unsigned TW = $clog2(TMO + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StSend = 3'd2;
  localparam logic [2:0] StGap  = 3'd3;
  localparam logic [2:0] StWait = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [GW-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [7:0]    pass_q, pass_d;
  logic [15:0]   rsp_len_q, rsp_len_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [DW-1:0] rsp_sum_q, rsp_sum_d, rd_data_q;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d, tmo_eff;
  logic          timeout_q, timeout_d;
  logic          accept, rsp_take, rd_en, pass_end;
  logic [2:0]    adv_state;
  logic [AW-1:0] adv_idx;
  logic [7:0]    adv_pass;

  logic [DW-1:0] mem [DEPTH];

  assign accept   = (state_q == StSend) & tx_data_rdy_i;
  assign rsp_take = rx_data_vld_i & (state_q != StIdle) & (state_q != StDone);
  assign pass_end = ({1'b0, idx_q} + (AW+1)'(1)) >= len_q;
  // A counted byte restarts the timeout window in the same cycle it arrives.
  assign tmo_eff  = rsp_take ? '0 : tmo_cnt_q;

  // Where to go once a byte (and its gap) is finished.
  always_comb begin
    adv_state = StLoad;
    adv_idx   = idx_q + AW'(1);
    adv_pass  = pass_q;
    if (pass_end) begin
      adv_idx = '0;
      if (pass_q != 8'd0) begin
        adv_pass = pass_q - 8'd1;
      end else begin
        adv_state = StWait;
        adv_idx   = idx_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    pass_d    = pass_q;
    rsp_len_d = rsp_len_q;
    tx_cnt_d  = tx_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    rsp_sum_d = rsp_sum_q;
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    rd_en     = 1'b0;

    // Counting happens even in an abort cycle.
    if (accept && tx_cnt_q != 16'hFFFF) tx_cnt_d = tx_cnt_q + 16'd1;
    if (rsp_take) begin
      if (rsp_cnt_q != 16'hFFFF) rsp_cnt_d = rsp_cnt_q + 16'd1;
      rsp_sum_d = rsp_sum_q ^ rx_data_i;
    end

    if (abort_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            len_d     = seq_len_i;
            gap_d     = gap_i;
            pass_d    = loop_cnt_i;
            rsp_len_d = rsp_len_i;
            idx_d     = '0;
            tx_cnt_d  = '0;
            rsp_cnt_d = '0;
            rsp_sum_d = '0;
            timeout_d = 1'b0;
            tmo_cnt_d = '0;
            state_d   = (seq_len_i != '0) ? StLoad : StWait;
          end
        end
        StLoad: begin
          rd_en   = 1'b1;
          state_d = StSend;
        end
        StSend: begin
          if (accept) begin
            if (gap_q != '0) begin
              gap_cnt_d = '0;
              state_d   = StGap;
            end else begin
              state_d   = adv_state;
              idx_d     = adv_idx;
              pass_d    = adv_pass;
              tmo_cnt_d = '0;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == gap_q - GW'(1)) begin
            state_d   = adv_state;
            idx_d     = adv_idx;
            pass_d    = adv_pass;
            tmo_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        StWait: begin
          if (rsp_cnt_q >= rsp_len_q) begin
            state_d = StDone;
          end else if (tmo_eff == TW'(TMO - 1) && !rsp_take) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
          end else begin
            tmo_cnt_d = tmo_eff + TW'(1);
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      pass_q    <= '0;
      rsp_len_q <= '0;
      tx_cnt_q  <= '0;
      rsp_cnt_q <= '0;
      rsp_sum_q <= '0;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      pass_q    <= pass_d;
      rsp_len_q <= rsp_len_d;
      tx_cnt_q  <= tx_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      rsp_sum_q <= rsp_sum_d;
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Table RAM: contents are not reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (tbl_wr_en_i && state_q == StIdle) mem[tbl_wr_addr_i] <= tbl_wr_data_i;
  end

  // Read register only loads in LOAD, so tx_data_o holds while the sink stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[idx_q];
    end
  end

  assign tx_data_o     = rd_data_q;
  assign tx_data_vld_o = (state_q == StSend);
  assign rx_data_rdy_o = 1'b1;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign timeout_o     = timeout_q;
  assign tx_cnt_o      = tx_cnt_q;
  assign rsp_cnt_o     = rsp_cnt_q;
  assign rsp_sum_o     = rsp_sum_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Self-checking bench for uart_cmd_seq (DEPTH=16, TMO=50).
module tb_uart_cmd_seq;
  localparam int unsigned DW = 8, DEPTH = 16, GW = 16, TMO = 50;

  logic        clk = 1'b0, rst = 1'b1;
  logic        tbl_wr_en = 1'b0;
  logic [3:0]  tbl_wr_addr = '0;
  logic [7:0]  tbl_wr_data = '0;
  logic [4:0]  seq_len = '0;
  logic [15:0] gap = '0;
  logic [7:0]  loop_cnt = '0;
  logic [15:0] rsp_len = '0;
  logic        start = 1'b0, abort = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_vld, tx_rdy = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_vld = 1'b0;
  logic        rx_rdy, busy, done, timeout;
  logic [15:0] tx_cnt, rsp_cnt;
  logic [7:0]  rsp_sum;

  uart_cmd_seq #(.DW(DW), .DEPTH(DEPTH), .GW(GW), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .tbl_wr_en_i(tbl_wr_en), .tbl_wr_addr_i(tbl_wr_addr), .tbl_wr_data_i(tbl_wr_data),
    .seq_len_i(seq_len), .gap_i(gap), .loop_cnt_i(loop_cnt), .rsp_len_i(rsp_len),
    .start_i(start), .abort_i(abort),
    .tx_data_o(tx_data), .tx_data_vld_o(tx_vld), .tx_data_rdy_i(tx_rdy),
    .rx_data_i(rx_data), .rx_data_vld_i(rx_vld), .rx_data_rdy_o(rx_rdy),
    .busy_o(busy), .done_o(done), .timeout_o(timeout),
    .tx_cnt_o(tx_cnt), .rsp_cnt_o(rsp_cnt), .rsp_sum_o(rsp_sum)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, run_s = 0, done_seen = 0;
  bit busy_at_done;
  bit mon_en = 1'b0;
  logic pv = 1'b0, pr = 1'b0, pa = 1'b0;
  logic [7:0] pd = '0;
  logic [7:0] tbl_m [16];
  logic [7:0] acc_q [$];
  int acc_c [$], rise_c [$], rx_off [$];
  logic [7:0] rx_byte [$];

  typedef struct {int len; int gap; int loops; int exp_n; int exp_done;} vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Observes the current cycle at the falling edge: accepted bytes, vld rises,
  // done pulses, and that a stalled byte stays put.
  task automatic mon();
    if (mon_en) begin
      if (pv && !pr && !pa) begin
        chk("hold_vld", {31'd0, tx_vld}, 1);
        chk("hold_data", {24'd0, tx_data}, {24'd0, pd});
      end
      if (tx_vld && !pv) rise_c.push_back(cyc);
      if (tx_vld && tx_rdy) begin
        acc_q.push_back(tx_data);
        acc_c.push_back(cyc);
      end
      if (done) done_seen++;
    end
    pv = tx_vld; pr = tx_rdy; pa = abort; pd = tx_data;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    tbl_wr_en = 1'b1; tbl_wr_addr = 4'(a); tbl_wr_data = d;
    tick();
    tbl_wr_en = 1'b0;
    tbl_m[a] = d;
  endtask

  // Start a sequence and run until done_o or timeout_o (offsets relative to start cycle).
  task automatic run_seq(input int len, input int g, input int loops, input int rl,
                         input int rdy_mode, input bit start_on_done,
                         output int done_k, output int to_k);
    int k;
    done_k = -1; to_k = -1;
    acc_q.delete(); acc_c.delete(); rise_c.delete(); done_seen = 0;
    seq_len = 5'(len); gap = 16'(g); loop_cnt = 8'(loops); rsp_len = 16'(rl);
    start = 1'b1; run_s = cyc;
    tick();
    start = 1'b0;
    for (k = 1; k <= 2000; k++) begin
      if (done) begin done_k = k; busy_at_done = busy; break; end
      if (timeout) begin to_k = k; break; end
      case (rdy_mode)
        0: tx_rdy = 1'b1;
        1: tx_rdy = (k % 4 == 3);
        default: tx_rdy = 1'($urandom_range(0, 1));
      endcase
      rx_vld = 1'b0;
      if (rx_off.size() > 0 && rx_off[0] == k) begin
        rx_vld = 1'b1; rx_data = rx_byte[0];
        void'(rx_off.pop_front()); void'(rx_byte.pop_front());
      end
      tick();
    end
    rx_vld = 1'b0; tx_rdy = 1'b1;
    if (done_k < 0 && to_k < 0) begin
      n_chk++; n_fail++;
      $display("FAIL seq_bound: neither done nor timeout within 2000 cycles, required one");
    end
    if (start_on_done) start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference: pass p, index i emits table[i]; vld rises gap+2 after each accept.
  task automatic check_stream(input int len, input int loops, input int g, input bit timing);
    int n = len * (loops + 1);
    chk("byte_count", acc_q.size(), n);
    for (int i = 0; i < n && i < acc_q.size(); i++)
      chk("tx_byte", {24'd0, acc_q[i]}, {24'd0, tbl_m[i % len]});
    if (timing && n > 0 && rise_c.size() > 0) begin
      chk("first_vld_cycle", rise_c[0] - run_s, 2);
      for (int i = 1; i < n && i < rise_c.size() && i <= acc_c.size(); i++)
        chk("vld_after_accept", rise_c[i] - acc_c[i-1], g + 2);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int dk, tk, rl, nb;
    logic [7:0] sum_m, b;

    vecs[0] = '{4, 0, 0, 4, 10};
    vecs[1] = '{2, 5, 2, 6, 44};
    vecs[2] = '{0, 0, 0, 0, 2};
    vecs[3] = '{1, 1, 3, 4, 14};
    vecs[4] = '{16, 0, 0, 16, 34};
    vecs[5] = '{3, 2, 1, 6, 26};

    tick(); tick();
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_vld", {31'd0, tx_vld}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    chk("rst_tx_cnt", tx_cnt, 0);
    chk("rst_rsp_cnt", rsp_cnt, 0);
    chk("rst_rsp_sum", {24'd0, rsp_sum}, 0);
    chk("rst_rx_rdy", {31'd0, rx_rdy}, 1);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    wr(0, 8'hB7); wr(1, 8'hB3); wr(2, 8'h00); wr(3, 8'h00);
    for (int a = 4; a < 16; a++) wr(a, 8'(8'h10 + a));

    // Abort mid-stream, with a start and a table write issued while busy.
    done_seen = 0;
    seq_len = 5'd4; gap = '0; loop_cnt = '0; rsp_len = '0; tx_rdy = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_at_cycle1", {31'd0, busy}, 1);
    tick();
    chk("abort_pre_vld", {31'd0, tx_vld}, 1);
    chk("abort_pre_data", {24'd0, tx_data}, 32'hB7);
    tx_rdy = 1'b1; tick();
    tx_rdy = 1'b0; seq_len = '0; start = 1'b1;
    tbl_wr_en = 1'b1; tbl_wr_addr = '0; tbl_wr_data = 8'hFF;
    tick();
    start = 1'b0; tbl_wr_en = 1'b0;
    chk("start_ignored_busy", {31'd0, busy}, 1);
    chk("start_ignored_cnt", tx_cnt, 1);
    chk("abort_vld_before", {31'd0, tx_vld}, 1);
    tx_rdy = 1'b1; abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_vld", {31'd0, tx_vld}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_accept_cnt", tx_cnt, 2);
    tick(); tick(); tick();
    chk("abort_no_done", done_seen, 0);

    // Table-driven runs, rdy held high.
    foreach (vecs[v]) begin
      run_seq(vecs[v].len, vecs[v].gap, vecs[v].loops, 0, 0, 1'b0, dk, tk);
      chk("vec_done_cycle", dk, vecs[v].exp_done);
      chk("vec_busy_at_done", {31'd0, busy_at_done}, 1);
      chk("vec_busy_after", {31'd0, busy}, 0);
      chk("vec_done_pulses", done_seen, 1);
      chk("vec_tx_cnt", tx_cnt, vecs[v].exp_n);
      chk("vec_timeout", {31'd0, timeout}, 0);
      check_stream(vecs[v].len, vecs[v].loops, vecs[v].gap, 1'b1);
    end

    // Stalling sink: rdy low 3 of every 4 cycles.
    run_seq(4, 0, 0, 0, 1, 1'b0, dk, tk);
    chk("stall_done", {31'd0, dk > 0}, 1);
    chk("stall_tx_cnt", tx_cnt, 4);
    check_stream(4, 0, 0, 1'b0);

    // Responses overlapping transmission and after it.
    rx_off = '{3, 5, 12}; rx_byte = '{8'h11, 8'h22, 8'h44};
    run_seq(4, 0, 0, 3, 0, 1'b0, dk, tk);
    chk("rsp_done_cycle", dk, 14);
    chk("rsp_cnt", rsp_cnt, 3);
    chk("rsp_sum", {24'd0, rsp_sum}, 32'h77);
    chk("rsp_timeout", {31'd0, timeout}, 0);
    rx_vld = 1'b1; rx_data = 8'h5A; tick(); rx_vld = 1'b0;
    chk("rsp_idle_discard", rsp_cnt, 3);

    // Timeout after the last counted byte, then from WAIT_RSP entry.
    rx_off = '{10}; rx_byte = '{8'h01};
    run_seq(0, 0, 0, 2, 0, 1'b0, dk, tk);
    chk("tmo_cycle", tk, 60);
    chk("tmo_sticky", {31'd0, timeout}, 1);
    chk("tmo_busy", {31'd0, busy}, 0);
    chk("tmo_no_done", done_seen, 0);
    chk("tmo_rsp_cnt", rsp_cnt, 1);
    run_seq(0, 0, 0, 1, 0, 1'b0, dk, tk);
    chk("tmo_entry_cycle", tk, 51);

    // Start clears timeout; start coincident with done_o is ignored.
    run_seq(0, 0, 0, 0, 0, 1'b1, dk, tk);
    chk("zero_len_done", dk, 2);
    chk("tmo_cleared", {31'd0, timeout}, 0);
    chk("start_at_done_ignored", {31'd0, busy}, 0);
    run_seq(0, 0, 0, 0, 0, 1'b0, dk, tk);
    chk("start_after_done", dk, 2);

    // Randomized runs against the reference stream and response model.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 16; a++) wr(a, 8'($urandom_range(0, 255)));
      rl = $urandom_range(0, 3);
      sum_m = '0;
      rx_off.delete(); rx_byte.delete();
      for (int j = 0; j < rl; j++) begin
        b = 8'($urandom_range(0, 255));
        rx_off.push_back(1 + 2 * j + $urandom_range(0, 1));
        rx_byte.push_back(b);
        sum_m = sum_m ^ b;
      end
      nb = $urandom_range(0, 16);
      tk = $urandom_range(0, 2);
      dk = $urandom_range(0, 3);
      begin
        int len_r = nb, loops_r = tk, gap_r = dk;
        run_seq(len_r, gap_r, loops_r, rl, 2, 1'b0, dk, tk);
        chk("rnd_done", {31'd0, dk > 0}, 1);
        chk("rnd_timeout", {31'd0, timeout}, 0);
        chk("rnd_tx_cnt", tx_cnt, len_r * (loops_r + 1));
        chk("rnd_rsp_cnt", rsp_cnt, rl);
        chk("rnd_rsp_sum", {24'd0, rsp_sum}, {24'd0, sum_m});
        check_stream(len_r, loops_r, gap_r, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_seq.md
# uart_cmd_seq

Parametrised, synthesizable command-byte sequencer for the UART loader path. Holds a writable table of up to DEPTH command bytes and streams it, with optional inter-byte gaps and repeat passes, into a `uart_tx`-style valid/ready byte sink. It then counts and checksums the response bytes arriving from a `uart_rx`-style source, and flags completion or a response timeout. It replaces hard-coded bench command tables and drives `ram_rw` / CPU bring-up sequences from on-chip logic.

## Interface
- DW, 8: byte width of table entries and stream data.
- DEPTH, 64: table entries; AW = $clog2(DEPTH).
- GW, 16: width of the inter-byte gap counter.
- TMO, 100000: response timeout in clock cycles; must be ≥ 1.

- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- tbl_wr_en_i  in  1  table write strobe; ignored while busy_o is high.
- tbl_wr_addr_i  in  AW  table write address.
- tbl_wr_data_i  in  DW  table write data.
- seq_len_i  in  AW+1  bytes per pass, 0..DEPTH; sampled at start.
- gap_i  in  GW  idle cycles inserted after each accepted byte; sampled at start.
- loop_cnt_i  in  8  extra passes; total passes = loop_cnt_i+1; sampled at start.
- rsp_len_i  in  16  expected response byte count; sampled at start.
- start_i  in  1  start pulse; ignored while busy_o is high.
- abort_i  in  1  abort; has priority over every other input except reset.
- tx_data_o  out  DW  byte to sink.
- tx_data_vld_o  out  1  byte valid.
- tx_data_rdy_i  in  1  sink ready.
- rx_data_i  in  DW  response byte.
- rx_data_vld_i  in  1  response byte valid.
- rx_data_rdy_o  out  1  constant 1 after reset; responses are never back-pressured.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse on normal completion.
- timeout_o  out  1  sticky response timeout; cleared by the next accepted start.
- tx_cnt_o  out  16  bytes accepted by the sink since the last start.
- rsp_cnt_o  out  16  response bytes counted since the last start.
- rsp_sum_o  out  DW  XOR of all counted response bytes.

## Operation
- Table: synchronous-write, synchronous-read RAM with 1-cycle read latency. Contents are not reset.
- State machine states: IDLE, LOAD, SEND, GAP, WAIT_RSP, DONE.
- IDLE → on start_i:
  - latch seq_len_i, gap_i, loop_cnt_i and rsp_len_i;
  - clear tx_cnt_o, rsp_cnt_o, rsp_sum_o and timeout_o;
  - go to LOAD if seq_len_i ≠ 0, else go to WAIT_RSP.
- LOAD: issue a read at the byte index; go to SEND.
- SEND: drive tx_data_vld_o=1 with the table byte. tx_data_o stays stable until the byte is accepted (vld & rdy in the same cycle).
  - On accept: tx_cnt_o++.
  - If gap ≠ 0, go to GAP.
  - Otherwise advance: next index → LOAD.
- GAP: count gap cycles, then advance.
- Advance rule:
  - index+1 < len: go to LOAD with the next index.
  - Pass complete and passes remaining: index=0, go to LOAD.
  - Last pass complete: go to WAIT_RSP.
- Response counting: every rx_data_vld_i cycle while busy_o is high increments rsp_cnt_o and XORs rx_data_i into rsp_sum_o. This applies in any state, so responses that overlap transmission are counted. Bytes received in IDLE/DONE are discarded.
- WAIT_RSP:
  - When rsp_cnt_o ≥ rsp_len (including rsp_len = 0), go to DONE.
  - A timeout counter clears on entry and on each counted byte. When it reaches TMO-1 without completion, set timeout_o and go to IDLE without pulsing done_o.
- DONE: pulse done_o for one cycle, then go to IDLE.
- abort_i: go to IDLE the next cycle. tx_data_vld_o drops, no done_o pulse, counters hold their values. An abort in the same cycle as an accept still counts that accept.
- tx_cnt_o and rsp_cnt_o saturate at 16'hFFFF.

## Timing
- Reset values: tx_data_o=0, tx_data_vld_o=0, busy_o=0, done_o=0, timeout_o=0, all counters and rsp_sum_o = 0, rx_data_rdy_o=1, state IDLE.
- Start sampled at cycle 0:
  - busy_o=1 at cycle 1 (state LOAD);
  - tx_data_vld_o=1 with byte 0 at cycle 2.
- gap=0: one LOAD bubble between bytes, so the minimum byte period is 2 cycles with rdy held high.
- gap=G: the next vld rises G+2 cycles after the accept cycle.
- done_o asserts on the cycle after completion is detected. busy_o falls on the same cycle done_o falls.
- Timeout: timeout_o rises TMO cycles after WAIT_RSP entry or after the last counted byte, whichever is later.
- A start in the same cycle that done_o is high is ignored. A start is accepted from the cycle after that.

## Test plan
- Load 4 bytes B7,B3,00,00; len=4, gap=0, loops=0, rsp_len=0, rdy held high → tx bytes B7,B3,00,00 on cycles 2,4,6,8; done_o pulses; tx_cnt_o=4.
- Same table with rdy toggling low 3 cycles per byte → tx_data_o stable while vld is high and rdy is low; no byte dropped or duplicated; tx_cnt_o=4.
- len=2, gap=5, loops=2 → 6 bytes in order A,B,A,B,A,B; vld rises exactly 7 cycles after each accept.
- rsp_len=3, response bytes 11,22,44 injected mid-stream and after the last tx byte → done_o pulses; rsp_cnt_o=3; rsp_sum_o=77; timeout_o=0.
- rsp_len=2, TMO=50, only 1 response byte → timeout_o=1 50 cycles after that byte; no done_o pulse; next start clears timeout_o.
- abort_i while vld is high mid-sequence → vld=0 and busy_o=0 the next cycle; no done_o pulse; a start_i issued while busy is ignored; seq_len=0 with rsp_len=0 → done_o pulses at cycle 2.
